// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC AD-bus sequencer: state encoding,
// default phase widths and a helper that turns a width into a timer load.
package rtc_bus_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ADDR = 3'd1,
      S_GAP1 = 3'd2,
      S_DATA = 3'd3,
      S_GAP2 = 3'd4,
      S_DONE = 3'd5
   } state_t;

   localparam int T_PULSE_DEF = 10;
   localparam int T_GAP_DEF   = 10;

   // The timer counts load..0 inclusive, so a phase of n cycles loads n-1.
   function automatic logic [7:0] phase_load(input int cycles);
      return 8'(cycles - 1);
   endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable 8-bit down-counter; zero marks the last cycle of a phase.
module rtc_phase_timer (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic       zero
);

   logic [7:0] count;

   // Load takes priority; otherwise count down and park at zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         count <= 8'd0;
      else if (load)
         count <= load_val;
      else if (count != 8'd0)
         count <= count - 8'd1;
   end

   assign zero = (count == 8'd0);

endmodule

// File: rtl/rtc_bus_seq.sv
// RTC multiplexed AD-bus sequencer: address strobe, gap, data strobe, gap,
// one-cycle done. Every output is a flop loaded from the decode of the next
// state, so nothing on the ports is combinational from the inputs.
// Optional feature: define RTC_BUS_COLLISION_EN to add the sticky err output
// that flags a start request arriving while busy.
module rtc_bus_seq
   import rtc_bus_pkg::*;
#(
   parameter int T_PULSE = T_PULSE_DEF,
   parameter int T_GAP   = T_GAP_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       rw,
   input  logic [7:0] addr,
   input  logic [7:0] wdata,
   input  logic [7:0] ad_in,
   output logic [7:0] ad_out,
   output logic       ad_oe,
   output logic       a_d,
   output logic       cs,
   output logic       rd,
   output logic       wr,
   output logic [7:0] rdata,
   output logic       busy,
   output logic       done
`ifdef RTC_BUS_COLLISION_EN
   ,
   output logic       err
`endif
);

   localparam logic [7:0] PULSE_LD = phase_load(T_PULSE);
   localparam logic [7:0] GAP_LD   = phase_load(T_GAP);

   state_t     state, state_nxt;
   logic       tmr_load;
   logic [7:0] tmr_val;
   logic       tmr_zero;

   logic       rw_q;
   logic [7:0] addr_q, wdata_q;

   logic       accept;
   logic       rw_eff;
   logic [7:0] addr_eff, wdata_eff;
   logic       capture;

   logic       cs_nxt, rd_nxt, wr_nxt, a_d_nxt, ad_oe_nxt;
   logic       busy_nxt, done_nxt;
   logic [7:0] ad_out_nxt;

   rtc_phase_timer u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   // A request is only honoured from IDLE; everywhere else it is dropped.
   assign accept = (state == S_IDLE) && start;

   // On the accepting edge the latches are not yet loaded, so the first
   // ADDR cycle takes its fields straight from the request inputs.
   assign rw_eff    = accept ? rw    : rw_q;
   assign addr_eff  = accept ? addr  : addr_q;
   assign wdata_eff = accept ? wdata : wdata_q;

   // Read data is sampled on the final DATA cycle, while rd is still low.
   assign capture = (state == S_DATA) && tmr_zero && rw_q;

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic; each phase exit reloads the timer for the next one.
   always_comb begin
      state_nxt = state;
      tmr_load  = 1'b0;
      tmr_val   = 8'd0;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_ADDR;
               tmr_load  = 1'b1;
               tmr_val   = PULSE_LD;
            end
         end
         S_ADDR: begin
            if (tmr_zero) begin
               state_nxt = S_GAP1;
               tmr_load  = 1'b1;
               tmr_val   = GAP_LD;
            end
         end
         S_GAP1: begin
            if (tmr_zero) begin
               state_nxt = S_DATA;
               tmr_load  = 1'b1;
               tmr_val   = PULSE_LD;
            end
         end
         S_DATA: begin
            if (tmr_zero) begin
               state_nxt = S_GAP2;
               tmr_load  = 1'b1;
               tmr_val   = GAP_LD;
            end
         end
         S_GAP2: begin
            if (tmr_zero)
               state_nxt = S_DONE;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output decode of the state being entered; the result is registered.
   always_comb begin
      cs_nxt     = 1'b1;
      rd_nxt     = 1'b1;
      wr_nxt     = 1'b1;
      a_d_nxt    = 1'b1;
      ad_oe_nxt  = 1'b0;
      ad_out_nxt = ad_out;
      busy_nxt   = (state_nxt != S_IDLE);
      done_nxt   = (state_nxt == S_DONE);
      unique case (state_nxt)
         S_ADDR: begin
            cs_nxt     = 1'b0;
            wr_nxt     = 1'b0;
            a_d_nxt    = 1'b0;
            ad_oe_nxt  = 1'b1;
            ad_out_nxt = addr_eff;
         end
         S_GAP1: begin
            // Keep driving the address so the bus never floats mid-cycle.
            ad_oe_nxt  = 1'b1;
            ad_out_nxt = addr_eff;
         end
         S_DATA: begin
            cs_nxt = 1'b0;
            if (rw_eff) begin
               rd_nxt = 1'b0;
            end else begin
               wr_nxt     = 1'b0;
               ad_oe_nxt  = 1'b1;
               ad_out_nxt = wdata_eff;
            end
         end
         default: ;
      endcase
   end

   // Request field latches, loaded only when a request is accepted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rw_q    <= 1'b0;
         addr_q  <= 8'h00;
         wdata_q <= 8'h00;
      end else if (accept) begin
         rw_q    <= rw;
         addr_q  <= addr;
         wdata_q <= wdata;
      end
   end

   // Registered outputs; reset forces the bus idle and clears read data.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cs     <= 1'b1;
         rd     <= 1'b1;
         wr     <= 1'b1;
         a_d    <= 1'b1;
         ad_oe  <= 1'b0;
         ad_out <= 8'h00;
         rdata  <= 8'h00;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         cs     <= cs_nxt;
         rd     <= rd_nxt;
         wr     <= wr_nxt;
         a_d    <= a_d_nxt;
         ad_oe  <= ad_oe_nxt;
         ad_out <= ad_out_nxt;
         busy   <= busy_nxt;
         done   <= done_nxt;
         if (capture)
            rdata <= ad_in;
      end
   end

`ifdef RTC_BUS_COLLISION_EN
   // Sticky collision flag: any request seen while busy is reported.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         err <= 1'b0;
      else if (start && busy)
         err <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_rtc_bus_seq.sv
// Bench for rtc_bus_seq: a default-timing instance and a T_PULSE=T_GAP=1
// instance share stimulus; each is compared every cycle against a
// transaction-level model that derives the expected bus phase from the
// cycle offset since the accepted request.
module tb_rtc_bus_seq;

   logic       clk = 1'b0, reset = 1'b1, start = 1'b0, rw = 1'b0;
   logic [7:0] addr = 8'h00, wdata = 8'h00, ad_in = 8'h00;

   logic [7:0] ad_out0, ad_out1, rdata0, rdata1;
   logic       ad_oe0, ad_oe1, a_d0, a_d1, cs0, cs1, rd0, rd1, wr0, wr1;
   logic       busy0, busy1, done0, done1;
`ifdef RTC_BUS_COLLISION_EN
   logic       err0, err1;
`endif

   always #5 clk = ~clk;

   rtc_bus_seq dut0 (
      .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr),
      .wdata(wdata), .ad_in(ad_in), .ad_out(ad_out0), .ad_oe(ad_oe0),
      .a_d(a_d0), .cs(cs0), .rd(rd0), .wr(wr0), .rdata(rdata0),
      .busy(busy0), .done(done0)
`ifdef RTC_BUS_COLLISION_EN
      , .err(err0)
`endif
   );

   rtc_bus_seq #(.T_PULSE(1), .T_GAP(1)) dut1 (
      .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr),
      .wdata(wdata), .ad_in(ad_in), .ad_out(ad_out1), .ad_oe(ad_oe1),
      .a_d(a_d1), .cs(cs1), .rd(rd1), .wr(wr1), .rdata(rdata1),
      .busy(busy1), .done(done1)
`ifdef RTC_BUS_COLLISION_EN
      , .err(err1)
`endif
   );

   typedef struct packed {
      logic cs, rd, wr, a_d, ad_oe, busy, done;
   } strb_t;

   strb_t s0, s1;
   assign s0 = {cs0, rd0, wr0, a_d0, ad_oe0, busy0, done0};
   assign s1 = {cs1, rd1, wr1, a_d1, ad_oe1, busy1, done1};

   // Model state per instance.
   int         mp[2], mg[2];
   bit         m_act[2];
   int         m_t0[2];
   bit         m_rw[2];
   logic [7:0] m_addr[2], m_wdata[2], m_rdata[2];
   bit         m_err[2];
   int         done_cnt[2], done_lat[2];
   int         cyc;
   int         pass_cnt = 0, chk_cnt = 0;

   typedef struct {
      bit         rw;
      logic [7:0] addr, wdata, din, exp_rdata;
   } vec_t;
   vec_t tbl[6];

   task automatic chk(input string name, input int i, input logic [31:0] act,
                      input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", name, i, cyc, act, exp);
   endtask

   function automatic int m_k(input int i);
      return cyc - m_t0[i];
   endfunction

   function automatic bit m_busy(input int i);
      int k;
      k = m_k(i);
      return m_act[i] && k >= 1 && k <= 2*mp[i] + 2*mg[i] + 1;
   endfunction

   task automatic check_dut(input int i);
      strb_t a, e;
      logic [7:0] ado, rdo, ead;
      int k, p, g;
      bit bsy, chk_ad;
      p = mp[i]; g = mg[i]; k = m_k(i); bsy = m_busy(i);
      if (i == 0) begin a = s0; ado = ad_out0; rdo = rdata0; end
      else        begin a = s1; ado = ad_out1; rdo = rdata1; end
      e = '{cs:1'b1, rd:1'b1, wr:1'b1, a_d:1'b1, ad_oe:1'b0, busy:bsy, done:1'b0};
      chk_ad = 1'b0; ead = 8'h00;
      if (bsy) begin
         if (k <= p) begin
            e.cs = 1'b0; e.wr = 1'b0; e.a_d = 1'b0; e.ad_oe = 1'b1;
            chk_ad = 1'b1; ead = m_addr[i];
         end else if (k <= p + g) begin
            e.ad_oe = 1'b1; chk_ad = 1'b1; ead = m_addr[i];
         end else if (k <= 2*p + g) begin
            e.cs = 1'b0;
            if (m_rw[i]) e.rd = 1'b0;
            else begin
               e.wr = 1'b0; e.ad_oe = 1'b1; chk_ad = 1'b1; ead = m_wdata[i];
            end
         end else if (k == 2*p + 2*g + 1) begin
            e.done = 1'b1;
         end
      end
      chk("strobes{cs,rd,wr,a_d,oe,busy,done}", i, 32'(a), 32'(e));
      chk("rdata", i, 32'(rdo), 32'(m_rdata[i]));
      if (chk_ad) chk("ad_out", i, 32'(ado), 32'(ead));
`ifdef RTC_BUS_COLLISION_EN
      chk("err", i, 32'((i == 0) ? err0 : err1), 32'(m_err[i]));
`endif
      if (a.done) begin
         done_cnt[i]++;
         done_lat[i] = k;
      end
   endtask

   task automatic model_update(input int i);
      int k;
      bit bsy;
      k = m_k(i); bsy = m_busy(i);
      if (bsy && m_rw[i] && k == 2*mp[i] + mg[i]) m_rdata[i] = ad_in;
      if (start && bsy) m_err[i] = 1'b1;
      if (start && !bsy) begin
         m_act[i] = 1'b1; m_t0[i] = cyc; m_rw[i] = rw;
         m_addr[i] = addr; m_wdata[i] = wdata;
      end
   endtask

   // One clock: check both instances, apply start, advance the models.
   task automatic step(input bit st);
      check_dut(0);
      check_dut(1);
      start = st;
      model_update(0);
      model_update(1);
      @(posedge clk); #1;
      cyc++;
   endtask

   task automatic set_in(input bit r, input logic [7:0] a, input logic [7:0] w,
                         input logic [7:0] d);
      rw = r; addr = a; wdata = w; ad_in = d;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_act[i] = 1'b0; m_rdata[i] = 8'h00; m_err[i] = 1'b0;
      end
   endtask

   // Asserts reset between clock edges and checks the forced idle state.
   task automatic reset_now();
      #2 reset = 1'b0;
      start = 1'b0;
      #1;
      model_reset();
      check_dut(0);
      check_dut(1);
      chk("rst_ad_out", 0, 32'(ad_out0), 32'h0);
      chk("rst_ad_out", 1, 32'(ad_out1), 32'h0);
      @(posedge clk); #3 reset = 1'b1;
      @(posedge clk); #1;
      cyc++;
   endtask

   initial begin
      int dc0, dc1;
      logic [7:0] keep;
      mp[0] = 10; mg[0] = 10; mp[1] = 1; mg[1] = 1;
      for (int i = 0; i < 2; i++) begin
         m_t0[i] = 0; m_rw[i] = 1'b0; m_addr[i] = 8'h00; m_wdata[i] = 8'h00;
         done_cnt[i] = 0; done_lat[i] = -1;
      end
      model_reset();
      cyc = 0;

      tbl[0] = '{rw:1'b0, addr:8'h22, wdata:8'h45, din:8'hAA, exp_rdata:8'h00};
      tbl[1] = '{rw:1'b1, addr:8'h21, wdata:8'h00, din:8'h37, exp_rdata:8'h37};
      tbl[2] = '{rw:1'b0, addr:8'h5A, wdata:8'hA5, din:8'hFF, exp_rdata:8'h37};
      tbl[3] = '{rw:1'b1, addr:8'hFF, wdata:8'h00, din:8'h00, exp_rdata:8'h00};
      tbl[4] = '{rw:1'b1, addr:8'h00, wdata:8'h3C, din:8'hC3, exp_rdata:8'hC3};
      tbl[5] = '{rw:1'b0, addr:8'h81, wdata:8'h7E, din:8'h11, exp_rdata:8'hC3};

      // Power-on reset without any clock edge in between.
      #1 reset = 1'b0;
      #2;
      check_dut(0);
      check_dut(1);
      chk("por_ad_out", 0, 32'(ad_out0), 32'h0);
      chk("por_ad_out", 1, 32'(ad_out1), 32'h0);
      @(posedge clk); #3 reset = 1'b1;
      @(posedge clk); #1;

      // Table-driven single transactions.
      for (int t = 0; t < 6; t++) begin
         dc0 = done_cnt[0]; dc1 = done_cnt[1];
         set_in(tbl[t].rw, tbl[t].addr, tbl[t].wdata, tbl[t].din);
         step(1'b1);
         for (int n = 0; n < 45; n++) step(1'b0);
         chk("tbl_rdata", 0, 32'(rdata0), 32'(tbl[t].exp_rdata));
         chk("tbl_rdata", 1, 32'(rdata1), 32'(tbl[t].exp_rdata));
         chk("tbl_done_lat", 0, 32'(done_lat[0]), 32'd41);
         chk("tbl_done_lat", 1, 32'(done_lat[1]), 32'd5);
         chk("tbl_done_cnt", 0, 32'(done_cnt[0] - dc0), 32'd1);
         chk("tbl_done_cnt", 1, 32'(done_cnt[1] - dc1), 32'd1);
      end

      // Collision: a second request at cycle 15 must not disturb the write.
      dc0 = done_cnt[0]; dc1 = done_cnt[1]; keep = rdata0;
      set_in(1'b0, 8'h33, 8'h66, 8'h00);
      step(1'b1);
      for (int n = 1; n < 15; n++) step(1'b0);
      set_in(1'b1, 8'hEE, 8'h11, 8'h5C);
      step(1'b1);
      for (int n = 16; n <= 45; n++) step(1'b0);
      chk("col_done_cnt", 0, 32'(done_cnt[0] - dc0), 32'd1);
      chk("col_done_cnt", 1, 32'(done_cnt[1] - dc1), 32'd2);
      chk("col_rdata", 0, 32'(rdata0), 32'(keep));
`ifdef RTC_BUS_COLLISION_EN
      chk("col_err", 0, 32'(err0), 32'd1);
`endif

      // Back-to-back: start in DONE is dropped, the next cycle is taken.
      set_in(1'b0, 8'h44, 8'h55, 8'h00);
      step(1'b1);
      for (int n = 1; n <= 40; n++) step(1'b0);
      chk("b2b_done_in_done_cycle", 0, 32'(done0), 32'd1);
      set_in(1'b1, 8'h99, 8'h00, 8'h77);
      step(1'b1);
      chk("b2b_idle_after_done", 0, 32'(busy0), 32'd0);
      step(1'b1);
      chk("b2b_busy_again", 0, 32'(busy0), 32'd1);
      for (int n = 0; n < 44; n++) step(1'b0);
      chk("b2b_rdata", 0, 32'(rdata0), 32'h77);

      // Reset in the middle of a read DATA phase.
      dc0 = done_cnt[0];
      set_in(1'b1, 8'h21, 8'h00, 8'h99);
      step(1'b1);
      for (int n = 1; n <= 24; n++) step(1'b0);
      chk("rst_pre_in_data", 0, 32'(rd0), 32'd0);
      reset_now();
      for (int n = 0; n < 50; n++) step(1'b0);
      chk("rst_no_done", 0, 32'(done_cnt[0] - dc0), 32'd0);
      chk("rst_rdata", 0, 32'(rdata0), 32'h00);

      // Minimum timing instance: one cycle per phase, done at cycle 5.
      dc1 = done_cnt[1];
      set_in(1'b1, 8'h12, 8'h34, 8'h6B);
      step(1'b1);
      chk("t1_addr_phase", 1, 32'({cs1, wr1, a_d1}), 32'b000);
      for (int n = 1; n <= 6; n++) step(1'b0);
      chk("t1_done_lat", 1, 32'(done_lat[1]), 32'd5);
      chk("t1_done_cnt", 1, 32'(done_cnt[1] - dc1), 32'd1);
      chk("t1_rdata", 1, 32'(rdata1), 32'h6B);
      for (int n = 7; n <= 45; n++) step(1'b0);

      // Randomized traffic, including requests while busy.
      for (int n = 0; n < 600; n++) begin
         set_in(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom));
         step($urandom_range(0, 24) == 0);
      end
      for (int n = 0; n < 45; n++) step(1'b0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/rtc_bus_seq.md
RTC_BUS_SEQ -- requirements
Module: rtc_bus_seq

Interface
REQ-001 SHALL have parameter T_PULSE, default 10, giving strobe-low width in clk cycles (legal range 1..255).
REQ-002 SHALL have parameter T_GAP, default 10, giving all-strobes-high width between phases in clk cycles (legal range 1..255).
REQ-003 SHALL have port clk  in  1  system clock; all logic rises on posedge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  in  1  one-cycle transaction request.
REQ-006 SHALL have port rw  in  1  1 = read, 0 = write; sampled with start.
REQ-007 SHALL have port addr  in  8  RTC register address; sampled with start.
REQ-008 SHALL have port wdata  in  8  write data; sampled with start.
REQ-009 SHALL have port ad_in  in  8  bus value returned from the tri-state buffer.
REQ-010 SHALL have port ad_out  out  8  value driven toward the AD bus.
REQ-011 SHALL have port ad_oe  out  1  1 = buffer drives AD.
REQ-012 SHALL have outputs a_d, cs, rd and wr  out  1 each  RTC strobes; cs, rd and wr are active-low, and a_d is 0 in the address phase and 1 in the data phase.
REQ-013 SHALL have port rdata  out  8  last read result.
REQ-014 SHALL have port busy  out  1  transaction in progress.
REQ-015 SHALL have port done  out  1  one-cycle completion pulse.

Function
REQ-016 SHALL implement FSM states IDLE, ADDR, GAP1, DATA, GAP2, DONE, with an 8-bit phase counter.
REQ-017 SHALL accept start only in IDLE, latching rw, addr and wdata, and SHALL enter ADDR on the next cycle.
REQ-018 ADDR SHALL last T_PULSE cycles with cs=0, wr=0, rd=1, a_d=0, ad_oe=1 and ad_out=addr.
REQ-019 GAP1 SHALL last T_GAP cycles with cs=1, rd=1, wr=1, a_d=1, ad_oe=1 and ad_out=addr held.
REQ-020 DATA SHALL last T_PULSE cycles with cs=0 and a_d=1.
REQ-021 In a DATA write, wr SHALL be 0, rd 1, ad_oe 1 and ad_out=wdata.
REQ-022 In a DATA read, rd SHALL be 0, wr 1 and ad_oe 0.
REQ-023 On a read, ad_in SHALL be captured into rdata on the last DATA cycle.
REQ-024 GAP2 SHALL last T_GAP cycles with all strobes high and ad_oe=0.
REQ-025 DONE SHALL last 1 cycle with done=1, then return to IDLE.
REQ-026 With the start cycle as cycle 0, done SHALL be high in cycle 2*T_PULSE+2*T_GAP+1, which is 41 with the defaults.
REQ-027 busy SHALL be 1 from cycle 1 through the DONE cycle inclusive, and 0 in IDLE.
REQ-028 start while busy SHALL be ignored; it is neither queued nor allowed to alter latched fields.
REQ-029 start in the DONE cycle SHALL be ignored; start in the first IDLE cycle after DONE SHALL be accepted.
REQ-030 rdata SHALL change only on a read capture, and a write SHALL leave it unchanged.
REQ-031 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-032 On assertion of reset, the block SHALL immediately force IDLE with cs=1, rd=1, wr=1, a_d=1, ad_oe=0, ad_out=0x00, rdata=0x00, busy=0 and done=0, including mid-transaction.
REQ-033 A transaction interrupted by reset SHALL NOT produce done, and SHALL NOT update rdata.

Configuration
REQ-034 SHALL implement macro RTC_BUS_COLLISION_EN.
REQ-035 With RTC_BUS_COLLISION_EN defined, the block SHALL add output err (1 bit), a sticky flag set when start arrives while busy=1 and cleared only by reset, with reset value 0.
REQ-036 Without RTC_BUS_COLLISION_EN, the err port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-037 The state encoding enum and the default T_PULSE and T_GAP constants SHALL reside in shared package rtc_bus_pkg.
REQ-038 One sub-module, rtc_phase_timer (a loadable 8-bit down-counter with a zero flag), SHALL supply the phase duration count; all other logic SHALL be flat.

Verification
REQ-039 The bench SHALL cover: a write with addr=0x22 and wdata=0x45 -> cs/wr low cycles 1-10 with ad_out=0x22, then cs/wr low cycles 21-30 with ad_out=0x45 and a_d=1, then done at cycle 41, with rdata unchanged.
REQ-040 The bench SHALL cover: a read with addr=0x21 and ad_in=0x37 during DATA -> rd low cycles 21-30, ad_oe=0 in DATA/GAP2, then rdata=0x37 and done at cycle 41.
REQ-041 The bench SHALL cover: start pulsed at cycle 15 of a transaction -> latched fields unchanged, a single done, and err=1 when RTC_BUS_COLLISION_EN is defined.
REQ-042 The bench SHALL cover: reset asserted during DATA of a read -> all strobes high and ad_oe=0 immediately, no done, and rdata=0x00.
REQ-043 The bench SHALL cover: back-to-back transactions, with start in the DONE cycle ignored and start in the next cycle accepted -> busy high again the following cycle.
REQ-044 The bench SHALL cover: T_PULSE=1 and T_GAP=1 -> done at cycle 5, with each phase exactly one cycle.
